// File: rtl/i8254_bus_master.sv
// Host-side bus initiator for an 8254-style counter 0: turns single-word commands into CS_N/IOW_N/IOR_N cycles.
// Define BCD_CHECK_EN to reject BCD-invalid or mode x11 count==1 writes before any bus cycle is issued.
module i8254_bus_master #(
   parameter int SETUP_CYC  = 1,
   parameter int STROBE_CYC = 2,
   parameter int HOLD_CYC   = 1,
   parameter int RECOV_CYC  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [1:0]  cmd_rw,
   input  logic [2:0]  cmd_mode,
   input  logic        cmd_bcd,
   input  logic [15:0] cmd_count,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [15:0] rsp_count,
   output logic [7:0]  rsp_status,
   output logic        CS_N,
   output logic [1:0]  a,
   output logic [7:0]  bus_wd,
   input  logic [7:0]  bus_rd,
   output logic        IOW_N,
   output logic        IOR_N
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOV, S_DONE} state_t;
   localparam logic [1:0] OP_PROGRAM = 2'b00, OP_WRITE = 2'b01, OP_LATCH = 2'b10, OP_READBACK = 2'b11;
   // Per-bus-cycle kind: write, or a read routed to status / count LSB / count MSB.
   localparam logic [1:0] K_WR = 2'd0, K_ST = 2'd1, K_LSB = 2'd2, K_MSB = 2'd3;
   localparam logic [7:0] SET_L = 8'(SETUP_CYC - 1);
   localparam logic [7:0] STB_L = 8'(STROBE_CYC - 1);
   localparam logic [7:0] HLD_L = 8'(HOLD_CYC - 1);
   localparam logic [7:0] REC_L = 8'(RECOV_CYC - 1);

   state_t      state, state_nx;
   logic [7:0]  cnt;
   logic [1:0]  idx, last_idx, op_q;
   logic        last_ph, accept;
   logic [1:0]  rw_shadow;
   logic [2:0]  mode_shadow;
   logic        bcd_shadow;
   logic [1:0]  ent_k [4];
   logic [1:0]  ent_a [4];
   logic [7:0]  ent_d [4];
   logic [1:0]  bk [4];
   logic [1:0]  ba [4];
   logic [7:0]  bd [4];
   logic [2:0]  pos;
   logic [1:0]  b_last, rw_eff;
   logic        b_err, wr_cnt;
   logic [7:0]  lsb_buf, msb_buf, stat_buf;

`ifdef BCD_CHECK_EN
   logic [2:0]  mode_eff;
   logic        bcd_eff;
   logic [15:0] loaded;

   function automatic logic byte_not_bcd(input logic [7:0] b);
      return (b[3:0] > 4'd9) || (b[7:4] > 4'd9);
   endfunction
`endif

   assign cmd_ready = (state == S_IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign rsp_valid = (state == S_DONE);
   assign CS_N      = !(state == S_SETUP || state == S_STROBE || state == S_HOLD);
   assign IOW_N     = !(state == S_STROBE && ent_k[idx] == K_WR);
   assign IOR_N     = !(state == S_STROBE && ent_k[idx] != K_WR);

   // Build the byte list for the offered command; registered only at acceptance.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bk[i] = K_WR;
         ba[i] = 2'd0;
         bd[i] = 8'h00;
      end
      pos    = 3'd1;
      b_err  = 1'b0;
      wr_cnt = (cmd_op == OP_PROGRAM) || (cmd_op == OP_WRITE);
      rw_eff = (cmd_op == OP_PROGRAM) ? cmd_rw : rw_shadow;
      case (cmd_op)
         OP_PROGRAM:  begin ba[0] = 2'd3; bd[0] = {2'b00, cmd_rw, cmd_mode, cmd_bcd}; end
         OP_WRITE:    pos = 3'd0;
         OP_LATCH:    begin ba[0] = 2'd3; bd[0] = 8'h00; end
         default:     begin ba[0] = 2'd3; bd[0] = 8'hC2; bk[1] = K_ST; pos = 3'd2; end
      endcase
      if (rw_eff[0]) begin
         bk[pos[1:0]] = wr_cnt ? K_WR : K_LSB;
         bd[pos[1:0]] = wr_cnt ? cmd_count[7:0] : 8'h00;
         pos = pos + 3'd1;
      end
      if (rw_eff[1]) begin
         bk[pos[1:0]] = wr_cnt ? K_WR : K_MSB;
         bd[pos[1:0]] = wr_cnt ? cmd_count[15:8] : 8'h00;
         pos = pos + 3'd1;
      end
      b_last = 2'(pos - 3'd1);
      if (cmd_op == OP_PROGRAM && cmd_rw == 2'b00) b_err = 1'b1;
`ifdef BCD_CHECK_EN
      mode_eff = (cmd_op == OP_PROGRAM) ? cmd_mode : mode_shadow;
      bcd_eff  = (cmd_op == OP_PROGRAM) ? cmd_bcd : bcd_shadow;
      loaded   = {rw_eff[1] ? cmd_count[15:8] : 8'h00, rw_eff[0] ? cmd_count[7:0] : 8'h00};
      if (wr_cnt) begin
         if (bcd_eff && ((rw_eff[0] && byte_not_bcd(cmd_count[7:0])) ||
                         (rw_eff[1] && byte_not_bcd(cmd_count[15:8])))) b_err = 1'b1;
         if (mode_eff[1:0] == 2'b11 && loaded == 16'd1) b_err = 1'b1;
      end
`endif
   end

   always_comb begin
      case (state)
         S_SETUP:  last_ph = (cnt == SET_L);
         S_STROBE: last_ph = (cnt == STB_L);
         S_HOLD:   last_ph = (cnt == HLD_L);
         S_RECOV:  last_ph = (cnt == REC_L);
         default:  last_ph = 1'b1;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (accept) state_nx = b_err ? S_DONE : S_SETUP;
         S_SETUP:  if (last_ph) state_nx = S_STROBE;
         S_STROBE: if (last_ph) state_nx = S_HOLD;
         S_HOLD:   if (last_ph) state_nx = S_RECOV;
         S_RECOV:  if (last_ph) state_nx = (idx == last_idx) ? S_DONE : S_SETUP;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= 8'd0;
         idx         <= 2'd0;
         a           <= 2'd0;
         bus_wd      <= 8'h00;
         rsp_err     <= 1'b0;
         rsp_count   <= 16'h0000;
         rsp_status  <= 8'h00;
         rw_shadow   <= 2'b01;
         mode_shadow <= 3'd0;
         bcd_shadow  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= (state_nx != state) ? 8'd0 : cnt + 8'd1;
         if (accept) begin
            idx     <= 2'd0;
            rsp_err <= b_err;
            if (!b_err) begin
               a      <= ba[0];
               bus_wd <= bd[0];
            end
            if (!b_err && cmd_op == OP_PROGRAM) begin
               rw_shadow   <= cmd_rw;
               mode_shadow <= cmd_mode;
               bcd_shadow  <= cmd_bcd;
            end
         end
         if (state == S_RECOV && last_ph) begin
            if (idx != last_idx) begin
               idx    <= idx + 2'd1;
               a      <= ent_a[idx + 2'd1];
               bus_wd <= ent_d[idx + 2'd1];
            end else if (op_q[1]) begin
               rsp_count <= {msb_buf, lsb_buf};
               if (op_q == OP_READBACK) rsp_status <= stat_buf;
            end
         end
      end
   end

   // Command list and read capture: datapath only, qualified by the FSM.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < 4; i++) begin
            ent_k[i] <= bk[i];
            ent_a[i] <= ba[i];
            ent_d[i] <= bd[i];
         end
         last_idx <= b_last;
         op_q     <= cmd_op;
         lsb_buf  <= 8'h00;
         msb_buf  <= 8'h00;
      end
      if (state == S_STROBE && last_ph) begin
         case (ent_k[idx])
            K_ST:    stat_buf <= bus_rd;
            K_LSB:   lsb_buf  <= bus_rd;
            K_MSB:   msb_buf  <= bus_rd;
            default: ;
         endcase
      end
   end

endmodule
